// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR multiply-accumulate block.
// Holds no logic: state encoding, data widths, default taps and rounding limits.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    MAC,
    OUT
  } state_t;

  localparam int DW = 16;
  localparam int CW = 16;

  typedef logic signed [CW-1:0] coef_t;

  // Eight taps of 1/8 in Q1.15 form a moving average.
  localparam coef_t COEF_DEFAULT [8] = '{default: 16'sh1000};

  localparam int RND_SHIFT = 15;
  localparam int RND_HALF  = 1 << (RND_SHIFT - 1);
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

endpackage

// File: rtl/fir_sat_round.sv
// Converts the wide Q-format accumulator back to a Q1.15 sample:
// round half up, arithmetic shift, then clamp to the 16-bit signed range.
module fir_sat_round
  import fir_pkg::*;
#(
  parameter int AW = 35
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] y
);

  localparam logic signed [AW-1:0] HALF = AW'(RND_HALF);
  localparam logic signed [AW-1:0] MAXV = AW'(SAT_MAX);
  localparam logic signed [AW-1:0] MINV = AW'(SAT_MIN);

  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] shifted;

  always_comb begin
    rounded = acc + HALF;
    shifted = rounded >>> RND_SHIFT;
    if (shifted > MAXV) begin
      y = DW'(SAT_MAX);
    end else if (shifted < MINV) begin
      y = DW'(SAT_MIN);
    end else begin
      y = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_mac.sv
// Serial FIR filter: pops one sample from an upstream FIFO, then runs one
// multiply-accumulate per tap over the delay line and emits a rounded result.
module fir_mac
  import fir_pkg::*;
#(
  parameter int    NTAPS        = 8,
  parameter coef_t COEFS [NTAPS] = COEF_DEFAULT
) (
  input  logic                 clk_rd,
  input  logic                 rst,
  input  logic signed [DW-1:0] fifo_rd_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int TW = $clog2(NTAPS);
  localparam int PW = DW + CW;
  localparam int AW = PW + TW;

  state_t state;
  state_t next_state;

  logic signed [DW-1:0] delay_line [NTAPS];
  logic        [TW-1:0] tap;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] product;
  logic signed [DW-1:0] rounded;
  logic signed [DW-1:0] out_hold;
  logic                 last_tap;

  assign product  = delay_line[tap] * COEFS[tap];
  assign last_tap = (tap == TW'(NTAPS - 1));

  fir_sat_round #(
    .AW(AW)
  ) u_sat_round (
    .acc(acc),
    .y  (rounded)
  );

  always_ff @(posedge clk_rd) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = WAIT;
      WAIT:    next_state = LOAD;
      LOAD:    next_state = MAC;
      MAC:     if (last_tap) next_state = OUT;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Delay line shifts on LOAD only, so history survives idle gaps between samples.
  always_ff @(posedge clk_rd) begin
    if (!rst) begin
      acc      <= '0;
      tap      <= '0;
      out_hold <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        delay_line[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          delay_line[0] <= fifo_rd_data;
          for (int i = 1; i < NTAPS; i++) begin
            delay_line[i] <= delay_line[i-1];
          end
          acc <= '0;
          tap <= '0;
        end
        MAC: begin
          acc <= acc + AW'(product);
          tap <= tap + 1'b1;
        end
        OUT: begin
          out_hold <= rounded;
        end
        default: begin
        end
      endcase
    end
  end

  // The pop strobe is gated by reset so nothing is consumed while the block is held.
  always_comb begin
    fifo_rd_en = rst && (state == IDLE) && !fifo_empty;
    out_valid  = (state == OUT);
    busy       = (state != IDLE);
    out_data   = (state == OUT) ? rounded : out_hold;
  end

endmodule

// File: tb/tb_fir_mac.sv
// Directed scoreboard bench for fir_mac: one default-coefficient instance and one
// saturation instance share a FIFO model; only the selected instance ever sees data.
module tb_fir_mac;
  import fir_pkg::*;

  localparam int NT  = 8;
  localparam int LAT = NT + 3;
  localparam coef_t SAT_COEFS [NT] = '{default: 16'sh4000};

  logic                 clk_rd = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] fifo_rd_data;
  logic                 fifo_empty [2];
  logic                 fifo_rd_en [2];
  logic signed [DW-1:0] out_data [2];
  logic                 out_valid [2];
  logic                 busy [2];

  fir_mac #(
    .NTAPS(NT)
  ) dut (
    .clk_rd      (clk_rd),
    .rst         (rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty[0]),
    .fifo_rd_en  (fifo_rd_en[0]),
    .out_data    (out_data[0]),
    .out_valid   (out_valid[0]),
    .busy        (busy[0])
  );

  fir_mac #(
    .NTAPS(NT),
    .COEFS(SAT_COEFS)
  ) dut_sat (
    .clk_rd      (clk_rd),
    .rst         (rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty[1]),
    .fifo_rd_en  (fifo_rd_en[1]),
    .out_data    (out_data[1]),
    .out_valid   (out_valid[1]),
    .busy        (busy[1])
  );

  always #5 clk_rd = ~clk_rd;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int act      = 0;
  bit hold_empty   = 1'b0;
  bit toggle_empty = 1'b0;
  bit prev_rd      = 1'b0;

  int src_q [$];
  int exp_q [$];
  int lat_q [$];
  int got_q [$];
  int hist [2][NT];
  int last_out [2];

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: full-precision dot product of sample history and taps, round half up, clamp.
  function automatic int ref_out(input int d);
    longint sum;
    longint c;
    sum = 0;
    c   = (d == 0) ? 64'sd4096 : 64'sd16384;
    for (int k = 0; k < NT; k++) begin
      sum += longint'(hist[d][k]) * c;
    end
    sum = (sum + 16384) >>> 15;
    if (sum > 32767) return 32767;
    if (sum < -32768) return -32768;
    return int'(sum);
  endfunction

  task automatic update_empty();
    for (int d = 0; d < 2; d++) begin
      fifo_empty[d] = 1'b1;
    end
    fifo_empty[act] = (src_q.size() == 0) || hold_empty || (toggle_empty && (cycle % 2 == 1));
  endtask

  task automatic applyStimulus(input int value, input int count);
    repeat (count) src_q.push_back(value);
    update_empty();
  endtask

  task automatic step_cycle();
    bit pop;
    int s;
    @(negedge clk_rd);
    pop = (fifo_rd_en[act] === 1'b1);
    if (pop) begin
      checkOutput("rd_en_while_empty", fifo_empty[act], 0);
      checkOutput("rd_en_outside_idle", busy[act], 0);
      checkOutput("rd_en_back_to_back", prev_rd, 0);
      lat_q.push_back(cycle);
    end
    prev_rd = pop;
    if (out_valid[act] === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", out_valid[act], 0);
      end else begin
        checkOutput("out_data", out_data[act], exp_q.pop_front());
        checkOutput("latency", cycle - lat_q.pop_front(), LAT);
        got_q.push_back(out_data[act]);
        last_out[act] = out_data[act];
      end
    end else begin
      checkOutput("out_data_hold", out_data[act], last_out[act]);
    end
    @(posedge clk_rd);
    #1;
    cycle++;
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        last_out[d] = 0;
        for (int k = 0; k < NT; k++) hist[d][k] = 0;
      end
      exp_q.delete();
      lat_q.delete();
    end else if (pop && src_q.size() > 0) begin
      s = src_q.pop_front();
      fifo_rd_data = 16'(s);
      for (int k = NT - 1; k > 0; k--) hist[act][k] = hist[act][k-1];
      hist[act][0] = s;
      exp_q.push_back(ref_out(act));
    end
    update_empty();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step_cycle();
      n++;
    end
    checkOutput("drain_timeout", src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int n;
    rst          = 1'b0;
    fifo_rd_data = '0;
    for (int d = 0; d < 2; d++) begin
      last_out[d] = 0;
      for (int k = 0; k < NT; k++) hist[d][k] = 0;
    end
    update_empty();
    repeat (3) step_cycle();
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_busy", busy[d], 0);
      checkOutput("reset_rd_en", fifo_rd_en[d], 0);
      checkOutput("reset_out_valid", out_valid[d], 0);
      checkOutput("reset_out_data", out_data[d], 0);
    end
    rst = 1'b1;

    $display("[TB] impulse response");
    got_q.delete();
    applyStimulus(16384, 1);
    applyStimulus(0, 15);
    drain(400);
    checkOutput("impulse_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checkOutput("impulse_value", got_q[i], (i < 8) ? 2048 : 0);
    end

    $display("[TB] dc step");
    got_q.delete();
    applyStimulus(8000, 10);
    drain(300);
    checkOutput("dc_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checkOutput("dc_value", got_q[i], (i < 8) ? 1000 * (i + 1) : 8000);
    end

    $display("[TB] empty hold then toggling empty");
    got_q.delete();
    hold_empty = 1'b1;
    applyStimulus(1234, 1);
    applyStimulus(-5000, 1);
    applyStimulus(30000, 1);
    applyStimulus(-30000, 1);
    applyStimulus(777, 1);
    repeat (50) step_cycle();
    checkOutput("held_src_count", src_q.size(), 5);
    hold_empty   = 1'b0;
    toggle_empty = 1'b1;
    drain(600);
    toggle_empty = 1'b0;
    checkOutput("toggle_out_count", got_q.size(), 5);

    $display("[TB] saturation");
    act = 1;
    update_empty();
    got_q.delete();
    applyStimulus(32767, 8);
    applyStimulus(-32768, 8);
    drain(400);
    checkOutput("sat_count", got_q.size(), 16);
    if (got_q.size() >= 16) begin
      checkOutput("sat_pos", got_q[7], 32767);
      checkOutput("sat_neg", got_q[15], -32768);
    end

    $display("[TB] reset during MAC");
    act = 0;
    update_empty();
    applyStimulus(8000, 3);
    drain(200);
    got_q.delete();
    applyStimulus(8000, 1);
    n = 0;
    while (lat_q.size() == 0 && n < 50) begin
      step_cycle();
      n++;
    end
    checkOutput("abort_rd_seen", lat_q.size(), 1);
    start = (lat_q.size() > 0) ? lat_q[0] : cycle;
    while (cycle < start + 6 && n < 100) begin
      step_cycle();
      n++;
    end
    checkOutput("abort_in_mac", busy[0], 1);
    rst = 1'b0;
    step_cycle();
    rst = 1'b1;
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_out_valid", out_valid[0], 0);
    checkOutput("abort_out_data", out_data[0], 0);
    repeat (30) step_cycle();
    checkOutput("abort_no_output", got_q.size(), 0);
    applyStimulus(16384, 1);
    drain(100);
    checkOutput("post_reset_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      checkOutput("post_reset_impulse", got_q[0], 2048);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
